// File: rtl/prio_event_encoder.sv
// Registered N-source priority encoder: sticky event capture, fixed-priority or
// round-robin selection, one index per cycle through a valid/ready output slot.
module prio_event_encoder #(
  parameter  int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         rr_mode,
  output logic [W-1:0] out_idx,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] pending,
  output logic         overflow
);

  localparam logic [W:0] NW = (W+1)'(N);

  logic [N-1:0] r_pending;
  logic [W-1:0] r_idx;
  logic [W-1:0] r_ptr;
  logic         r_valid;
  logic         r_overflow;

  logic         w_slot_free;
  logic         w_issue;
  logic [W-1:0] w_sel_fixed;
  logic [W-1:0] w_sel_rr;
  logic [W-1:0] w_sel;
  logic [W-1:0] w_off;
  logic [W-1:0] w_ptr_next;
  logic [N-1:0] w_rot;
  logic [N-1:0] w_issue_onehot;
  logic [W:0]   w_lsh;
  logic [W:0]   w_sum;
  logic [W:0]   w_inc;

  assign w_slot_free = !r_valid || out_ready;
  assign w_issue     = w_slot_free && (|r_pending);

  always_comb begin
    w_sel_fixed = '0;
    for (int i = 0; i < N; i++) begin
      if (r_pending[i]) w_sel_fixed = W'(i);
    end
  end

  // Rotate pending so the pointer lands on bit 0; the lowest set bit is the RR offset.
  assign w_lsh = NW - {1'b0, r_ptr};
  assign w_rot = (r_pending >> r_ptr) | (r_pending << w_lsh);

  always_comb begin
    w_off = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (w_rot[k]) w_off = W'(k);
    end
  end

  assign w_sum      = {1'b0, r_ptr} + {1'b0, w_off};
  assign w_sel_rr   = (w_sum >= NW) ? W'(w_sum - NW) : w_sum[W-1:0];
  assign w_sel      = rr_mode ? w_sel_rr : w_sel_fixed;
  assign w_inc      = {1'b0, w_sel} + (W+1)'(1);
  assign w_ptr_next = (w_inc == NW) ? '0 : w_inc[W-1:0];

  assign w_issue_onehot = w_issue ? (N'(1) << w_sel) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending  <= '0;
      r_idx      <= '0;
      r_ptr      <= '0;
      r_valid    <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      // A request on the bit being issued this edge survives as a fresh event.
      r_pending  <= (r_pending & ~w_issue_onehot) | req;
      r_overflow <= |(req & r_pending & ~w_issue_onehot);
      if (w_slot_free) begin
        r_valid <= w_issue;
        if (w_issue) begin
          r_idx <= w_sel;
          r_ptr <= w_ptr_next;
        end
      end
    end
  end

  assign out_idx   = r_idx;
  assign out_valid = r_valid;
  assign pending   = r_pending;
  assign overflow  = r_overflow;

endmodule
